// File: rtl/pipe_phy_status_responder_if.sv
// PIPE MAC/PHY command and status bundle seen by the PHY status responder.
// The MAC (or bench) drives the commands; the PHY side returns the status.
interface pipe_phy_status_responder_if #(
    parameter int NUM_LANES = 16
);
    logic [4*NUM_LANES-1:0] PowerDown;
    logic [3:0]             Rate;
    logic [NUM_LANES-1:0]   TxDetectRxLoopback;
    logic [NUM_LANES-1:0]   TxElecIdle;
    logic [NUM_LANES-1:0]   rx_present;
    logic [NUM_LANES-1:0]   PhyStatus;
    logic [3*NUM_LANES-1:0] RxStatus;
    logic                   busy;
    logic                   proto_err;

    modport master (
        output PowerDown, Rate, TxDetectRxLoopback, TxElecIdle, rx_present,
        input  PhyStatus, RxStatus, busy, proto_err
    );

    modport slave (
        input  PowerDown, Rate, TxDetectRxLoopback, TxElecIdle, rx_present,
        output PhyStatus, RxStatus, busy, proto_err
    );
endinterface

// File: rtl/pipe_phy_status_responder.sv
// PHY-side PIPE status engine: reset-exit PhyStatus, PowerDown/Rate acks and
// receiver detection, with a sticky protocol-error flag.
module pipe_phy_status_responder #(
    parameter int NUM_LANES         = 16,
    parameter int RESET_EXIT_CYCLES = 8,
    parameter int PD_LATENCY        = 4,
    parameter int RATE_LATENCY      = 16,
    parameter int DETECT_LATENCY    = 10
) (
    input  logic                        PCLK,
    input  logic                        Reset,
    pipe_phy_status_responder_if.slave  pipe
);
    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_LAT = maxOf(maxOf(RESET_EXIT_CYCLES, PD_LATENCY),
                                   maxOf(RATE_LATENCY, DETECT_LATENCY));
    localparam int CW = $clog2(MAX_LAT + 1);
    localparam logic [3:0] P1 = 4'd2;
    localparam logic [3:0] P_MAX = 4'd3;

    typedef enum logic [2:0] {
        RESET_HOLD  = 3'd0,
        IDLE        = 3'd1,
        PD_WAIT     = 3'd2,
        RATE_WAIT   = 3'd3,
        DETECT_WAIT = 3'd4,
        ACK         = 3'd5
    } state_t;

    state_t                 state_r, stateNext_s;
    logic [CW-1:0]          count_r, countNext_s, latency_s;
    logic [3:0]             pdSh_r, pdShNext_s, rateSh_r, rateShNext_s;
    logic                   detPrev_r;
    logic                   phy_r, phyNext_s;
    logic                   busy_r, busyNext_s;
    logic                   protoErr_r, errSet_s;
    logic [3*NUM_LANES-1:0] rx_r, rxNext_s, rxDetect_s;
    logic [3:0]             pd0_s;
    logic                   laneMismatch_s, detRise_s, allIdle_s, cmdChange_s;

    assign pd0_s       = pipe.PowerDown[3:0];
    assign detRise_s   = pipe.TxDetectRxLoopback[0] & ~detPrev_r;
    assign allIdle_s   = &pipe.TxElecIdle;
    assign cmdChange_s = (pd0_s != pdSh_r) | (pipe.Rate != rateSh_r);

    // Per-lane helpers: PowerDown consistency and the detect result pattern.
    always_comb begin
        laneMismatch_s = 1'b0;
        rxDetect_s     = {(3*NUM_LANES){1'b0}};
        for (int i = 1; i < NUM_LANES; i++) begin
            laneMismatch_s = laneMismatch_s | (pipe.PowerDown[4*i +: 4] != pd0_s);
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            rxDetect_s[3*i +: 3] = pipe.rx_present[i] ? 3'b011 : 3'b000;
        end
    end

    // Completion latency of the operation currently pending.
    always_comb begin
        case (state_r)
            PD_WAIT:     latency_s = CW'(PD_LATENCY);
            RATE_WAIT:   latency_s = CW'(RATE_LATENCY);
            DETECT_WAIT: latency_s = CW'(DETECT_LATENCY);
            default:     latency_s = CW'(MAX_LAT);
        endcase
    end

    // Next-state, counter, shadow and registered-output computation.
    always_comb begin
        stateNext_s  = state_r;
        countNext_s  = count_r;
        pdShNext_s   = pdSh_r;
        rateShNext_s = rateSh_r;
        phyNext_s    = 1'b0;
        rxNext_s     = {(3*NUM_LANES){1'b0}};
        busyNext_s   = busy_r;
        errSet_s     = 1'b0;
        case (state_r)
            RESET_HOLD: begin
                // Shadows follow the inputs so nothing fires on exit.
                pdShNext_s   = pd0_s;
                rateShNext_s = pipe.Rate;
                if (count_r == CW'(RESET_EXIT_CYCLES)) begin
                    stateNext_s = IDLE;
                    countNext_s = {CW{1'b0}};
                    busyNext_s  = 1'b0;
                end else begin
                    countNext_s = count_r + CW'(1'b1);
                    phyNext_s   = 1'b1;
                    busyNext_s  = 1'b1;
                end
            end
            IDLE: begin
                busyNext_s = 1'b0;
                errSet_s   = laneMismatch_s | ((pdSh_r == P1) & detRise_s & ~allIdle_s);
                if (pipe.Rate != rateSh_r) begin
                    stateNext_s  = RATE_WAIT;
                    rateShNext_s = pipe.Rate;
                    pdShNext_s   = pd0_s;
                    countNext_s  = CW'(1'b1);
                    busyNext_s   = 1'b1;
                    errSet_s     = errSet_s | (pd0_s > P_MAX);
                end else if (pd0_s != pdSh_r) begin
                    stateNext_s = PD_WAIT;
                    pdShNext_s  = pd0_s;
                    countNext_s = CW'(1'b1);
                    busyNext_s  = 1'b1;
                    errSet_s    = errSet_s | (pd0_s > P_MAX);
                end else if ((pdSh_r == P1) && detRise_s && allIdle_s) begin
                    stateNext_s = DETECT_WAIT;
                    countNext_s = CW'(1'b1);
                    busyNext_s  = 1'b1;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            PD_WAIT, RATE_WAIT, DETECT_WAIT: begin
                busyNext_s = 1'b1;
                errSet_s   = cmdChange_s;
                if (count_r == latency_s) begin
                    stateNext_s = ACK;
                    phyNext_s   = 1'b1;
                    rxNext_s    = (state_r == DETECT_WAIT) ? rxDetect_s
                                                           : {(3*NUM_LANES){1'b0}};
                end else begin
                    countNext_s = count_r + CW'(1'b1);
                end
            end
            ACK: begin
                stateNext_s = IDLE;
                busyNext_s  = 1'b0;
            end
            default: begin
                stateNext_s = RESET_HOLD;
                countNext_s = {CW{1'b0}};
                phyNext_s   = 1'b1;
                busyNext_s  = 1'b1;
            end
        endcase
    end

    // State and output registers; a low Reset aborts any pending operation.
    always_ff @(posedge PCLK) begin
        if (!Reset) begin
            state_r    <= RESET_HOLD;
            count_r    <= {CW{1'b0}};
            pdSh_r     <= pd0_s;
            rateSh_r   <= pipe.Rate;
            detPrev_r  <= pipe.TxDetectRxLoopback[0];
            phy_r      <= 1'b1;
            rx_r       <= {(3*NUM_LANES){1'b0}};
            busy_r     <= 1'b1;
            protoErr_r <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            count_r    <= countNext_s;
            pdSh_r     <= pdShNext_s;
            rateSh_r   <= rateShNext_s;
            detPrev_r  <= pipe.TxDetectRxLoopback[0];
            phy_r      <= phyNext_s;
            rx_r       <= rxNext_s;
            busy_r     <= busyNext_s;
            protoErr_r <= protoErr_r | errSet_s;
        end
    end

    assign pipe.PhyStatus = {NUM_LANES{phy_r}};
    assign pipe.RxStatus  = rx_r;
    assign pipe.busy      = busy_r;
    assign pipe.proto_err = protoErr_r;
endmodule

// File: tb/tb_pipe_phy_status_responder.sv
// Directed self-checking bench for pipe_phy_status_responder with four lanes
// and the default latencies (reset exit 8, PD 4, rate 16, detect 10).
module tb_pipe_phy_status_responder;
    logic PCLK = 1'b0;
    logic Reset;
    int   total  = 0;
    int   passed = 0;

    always #5 PCLK = ~PCLK;

    pipe_phy_status_responder_if #(.NUM_LANES(4)) pipe ();

    pipe_phy_status_responder #(
        .NUM_LANES(4), .RESET_EXIT_CYCLES(8), .PD_LATENCY(4),
        .RATE_LATENCY(16), .DETECT_LATENCY(10)
    ) u_dut (
        .PCLK  (PCLK),
        .Reset (Reset),
        .pipe  (pipe)
    );

    // Advance one clock and sample just after the rising edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        pipe.PowerDown = 16'h0000;
        pipe.Rate = 4'd0;
        pipe.TxDetectRxLoopback = 4'b0000;
        pipe.TxElecIdle = 4'b0000;
        pipe.rx_present = 4'b0101;
        repeat (5) tick();
        total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL rst_phy: got %h want f", pipe.PhyStatus); else passed++;
        total++; if (pipe.busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", pipe.busy); else passed++;
        total++; if (pipe.RxStatus !== 12'h000) $display("FAIL rst_rx: got %h want 000", pipe.RxStatus); else passed++;
        total++; if (pipe.proto_err !== 1'b0) $display("FAIL rst_err: got %b want 0", pipe.proto_err); else passed++;
        Reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL exit_phy_%0d: got %h want f", k, pipe.PhyStatus); else passed++;
            total++; if (pipe.busy !== 1'b1) $display("FAIL exit_busy_%0d: got %b want 1", k, pipe.busy); else passed++;
        end
        tick();
        total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL exit_drop_phy: got %h want 0", pipe.PhyStatus); else passed++;
        total++; if (pipe.busy !== 1'b0) $display("FAIL exit_drop_busy: got %b want 0", pipe.busy); else passed++;
        repeat (3) begin
            tick();
            total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL exit_spurious: got %h want 0", pipe.PhyStatus); else passed++;
        end
    endtask

    task automatic test_powerdown();
        pipe.PowerDown = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL pd_early_%0d: got %h want 0", i, pipe.PhyStatus); else passed++;
            total++; if (pipe.busy !== 1'b1) $display("FAIL pd_busy_%0d: got %b want 1", i, pipe.busy); else passed++;
        end
        tick();
        total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL pd_pulse: got %h want f", pipe.PhyStatus); else passed++;
        total++; if (pipe.RxStatus !== 12'h000) $display("FAIL pd_rx: got %h want 000", pipe.RxStatus); else passed++;
        total++; if (pipe.busy !== 1'b1) $display("FAIL pd_busy_pulse: got %b want 1", pipe.busy); else passed++;
        tick();
        total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL pd_end: got %h want 0", pipe.PhyStatus); else passed++;
        total++; if (pipe.busy !== 1'b0) $display("FAIL pd_idle: got %b want 0", pipe.busy); else passed++;
        total++; if (pipe.proto_err !== 1'b0) $display("FAIL pd_err: got %b want 0", pipe.proto_err); else passed++;
    endtask

    task automatic test_detect();
        pipe.TxElecIdle = 4'hF;
        pipe.TxDetectRxLoopback = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL det_early_%0d: got %h want 0", i, pipe.PhyStatus); else passed++;
        end
        tick();
        total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL det_pulse: got %h want f", pipe.PhyStatus); else passed++;
        total++; if (pipe.RxStatus !== 12'h0C3) $display("FAIL det_rx: got %h want 0c3", pipe.RxStatus); else passed++;
        tick();
        total++; if (pipe.RxStatus !== 12'h000) $display("FAIL det_rx_clear: got %h want 000", pipe.RxStatus); else passed++;
        total++; if (pipe.busy !== 1'b0) $display("FAIL det_idle: got %b want 0", pipe.busy); else passed++;
        total++; if (pipe.proto_err !== 1'b0) $display("FAIL det_err: got %b want 0", pipe.proto_err); else passed++;
        pipe.TxDetectRxLoopback = 4'b0000;
        tick();
    endtask

    task automatic test_rate();
        pipe.Rate = 4'd1;
        pipe.PowerDown = 16'h3333;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL rate_early_%0d: got %h want 0", i, pipe.PhyStatus); else passed++;
        end
        tick();
        total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL rate_pulse: got %h want f", pipe.PhyStatus); else passed++;
        total++; if (pipe.RxStatus !== 12'h000) $display("FAIL rate_rx: got %h want 000", pipe.RxStatus); else passed++;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL rate_second_%0d: got %h want 0", i, pipe.PhyStatus); else passed++;
            total++; if (pipe.busy !== 1'b0) $display("FAIL rate_busy_%0d: got %b want 0", i, pipe.busy); else passed++;
        end
        total++; if (pipe.proto_err !== 1'b0) $display("FAIL rate_err: got %b want 0", pipe.proto_err); else passed++;
    endtask

    task automatic test_back_to_back();
        pipe.PowerDown = 16'h0000;
        repeat (6) tick();
        total++; if (pipe.busy !== 1'b0) $display("FAIL b2b_setup: got %b want 0", pipe.busy); else passed++;
        pipe.PowerDown = 16'h2222;
        tick();
        total++; if (pipe.busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", pipe.busy); else passed++;
        tick();
        pipe.PowerDown = 16'h3333;
        tick();
        total++; if (pipe.proto_err !== 1'b1) $display("FAIL b2b_err: got %b want 1", pipe.proto_err); else passed++;
        tick();
        total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL b2b_early: got %h want 0", pipe.PhyStatus); else passed++;
        tick();
        total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL b2b_pulse1: got %h want f", pipe.PhyStatus); else passed++;
        tick();
        total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL b2b_gap_phy: got %h want 0", pipe.PhyStatus); else passed++;
        total++; if (pipe.busy !== 1'b0) $display("FAIL b2b_gap_busy: got %b want 0", pipe.busy); else passed++;
        tick();
        total++; if (pipe.busy !== 1'b1) $display("FAIL b2b_restart: got %b want 1", pipe.busy); else passed++;
        repeat (3) begin
            tick();
            total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL b2b_wait: got %h want 0", pipe.PhyStatus); else passed++;
        end
        tick();
        total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL b2b_pulse2: got %h want f", pipe.PhyStatus); else passed++;
        tick();
        total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL b2b_end: got %h want 0", pipe.PhyStatus); else passed++;
        total++; if (pipe.proto_err !== 1'b1) $display("FAIL b2b_sticky: got %b want 1", pipe.proto_err); else passed++;
    endtask

    task automatic test_reset_abort();
        pipe.Rate = 4'd2;
        tick();
        total++; if (pipe.busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", pipe.busy); else passed++;
        repeat (5) tick();
        Reset = 1'b0;
        tick();
        total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL abort_phy: got %h want f", pipe.PhyStatus); else passed++;
        total++; if (pipe.proto_err !== 1'b0) $display("FAIL abort_err: got %b want 0", pipe.proto_err); else passed++;
        tick();
        Reset = 1'b1;
        repeat (8) tick();
        total++; if (pipe.PhyStatus !== 4'hF) $display("FAIL abort_exit_hold: got %h want f", pipe.PhyStatus); else passed++;
        tick();
        total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL abort_exit_drop: got %h want 0", pipe.PhyStatus); else passed++;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (pipe.PhyStatus !== 4'h0) $display("FAIL abort_no_pulse_%0d: got %h want 0", i, pipe.PhyStatus); else passed++;
        end
    endtask

    task automatic test_lane_mismatch();
        pipe.PowerDown = 16'h0333;
        tick();
        total++; if (pipe.proto_err !== 1'b1) $display("FAIL lane_err: got %b want 1", pipe.proto_err); else passed++;
        total++; if (pipe.busy !== 1'b0) $display("FAIL lane_busy: got %b want 0", pipe.busy); else passed++;
        pipe.PowerDown = 16'h3333;
        tick();
    endtask

    initial begin
        test_reset();
        test_powerdown();
        test_detect();
        test_rate();
        test_back_to_back();
        test_reset_abort();
        test_lane_mismatch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
